ascon_unpadder: RTL and testbench

- Output-side post-processor and the inverse of the input padder. Sits between the core/FSM output mux and the external AXI4-Stream master.
- Takes full 64-bit rate words from the core (CT, PT, digest, tag) and re-frames them into a byte-accurate stream:
  - zeroes invalid bytes;
  - removes the all-empty alignment word that AEAD's 128-bit rate produces;
  - moves tlast back onto the last real word;
  - reports the delivered byte count per packet.

---
 rtl/ascon_unpadder.sv | 182 ++++++++++++++++++
 tb/tb_ascon_unpadder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_unpadder.sv
// Output-side unpadder: re-frames 64-bit core rate words into a byte-accurate AXI4-Stream.
// Optional sticky framing-error detector enabled by defining ASCON_UNPADDER_ERR_EN.
package ascon_unpadder_pkg;
   typedef enum logic [2:0] {
      MODE_AEAD_ENC = 3'd0,
      MODE_AEAD_DEC = 3'd1,
      MODE_HASH     = 3'd2,
      MODE_XOF      = 3'd3,
      MODE_CXOF     = 3'd4
   } ascon_mode_t;

   typedef enum logic [1:0] {
      TUSER_CT  = 2'd0,
      TUSER_PT  = 2'd1,
      TUSER_MSG = 2'd2,
      TUSER_TAG = 2'd3
   } axi_tuser_t;
endpackage

module ascon_unpadder
   import ascon_unpadder_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter bit DROP_EMPTY = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  ascon_mode_t      mode_i,
   input  logic [63:0]      core_tdata_i,
   input  logic [7:0]       core_tkeep_i,
   input  axi_tuser_t       core_tuser_i,
   input  logic             core_tlast_i,
   input  logic             core_tvalid_i,
   output logic             core_tready_o,
   output logic [63:0]      m_axis_tdata_o,
   output logic [7:0]       m_axis_tkeep_o,
   output axi_tuser_t       m_axis_tuser_o,
   output logic             m_axis_tlast_o,
   output logic             m_axis_tvalid_o,
   input  logic             m_axis_tready_i,
   output logic [CNT_W-1:0] msg_bytes_o,
   output logic             err_o
);

   typedef enum logic [1:0] {HOLD_EMPTY, HOLD_WAIT, HOLD_LAST} state_t;

   state_t           r_state;
   logic             r_live;
   logic [63:0]      r_data;
   logic [7:0]       r_keep;
   axi_tuser_t       r_user;
   logic [CNT_W-1:0] r_count;

   logic [7:0]       w_inKeep;
   logic [63:0]      w_inData;
   logic             w_dropEn;
   logic             w_drop;
   logic             w_cFire;
   logic             w_mFire;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_total;

   function automatic logic [3:0] popcount8(input logic [7:0] k);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
      return c;
   endfunction

   // Tag words are always full; everything else is masked by its own keep.
   assign w_inKeep = (core_tuser_i == TUSER_TAG) ? 8'hFF : core_tkeep_i;

   always_comb begin
      w_inData = '0;
      for (int i = 0; i < 8; i++)
         w_inData[8*i +: 8] = w_inKeep[i] ? core_tdata_i[8*i +: 8] : 8'h00;
   end

   assign w_dropEn = DROP_EMPTY && (core_tuser_i != TUSER_TAG) &&
                     ((mode_i == MODE_AEAD_ENC) || (mode_i == MODE_AEAD_DEC));
   assign w_drop   = core_tlast_i && (core_tkeep_i == 8'h00) && w_dropEn;

   // Handshake controls; in HOLD_WAIT the visible core word decides tvalid/tlast.
   always_comb begin
      core_tready_o   = 1'b0;
      m_axis_tvalid_o = 1'b0;
      m_axis_tlast_o  = 1'b0;
      case (r_state)
         HOLD_EMPTY: core_tready_o = r_live;
         HOLD_WAIT: begin
            core_tready_o   = m_axis_tready_i;
            m_axis_tvalid_o = core_tvalid_i;
            m_axis_tlast_o  = w_drop;
         end
         HOLD_LAST: begin
            m_axis_tvalid_o = 1'b1;
            m_axis_tlast_o  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_cFire = core_tvalid_i && core_tready_o;
   assign w_mFire = m_axis_tvalid_o && m_axis_tready_i;

   assign m_axis_tdata_o = r_data;
   assign m_axis_tkeep_o = r_keep;
   assign m_axis_tuser_o = r_user;

   assign w_sum       = {1'b0, r_count} + (CNT_W+1)'(popcount8(r_keep));
   assign w_total     = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
   assign msg_bytes_o = (r_state == HOLD_EMPTY) ? r_count : w_total;

   // Hold register, state and byte counter; a dropped trailing word is consumed but never loaded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= HOLD_EMPTY;
         r_live  <= 1'b0;
         r_data  <= '0;
         r_keep  <= '0;
         r_user  <= TUSER_CT;
         r_count <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_mFire) r_count <= m_axis_tlast_o ? '0 : w_total;
         case (r_state)
            HOLD_EMPTY: begin
               if (w_cFire) begin
                  r_data  <= w_inData;
                  r_keep  <= w_inKeep;
                  r_user  <= core_tuser_i;
                  r_state <= core_tlast_i ? HOLD_LAST : HOLD_WAIT;
               end
            end
            HOLD_WAIT: begin
               if (w_mFire) begin
                  if (w_drop) begin
                     r_state <= HOLD_EMPTY;
                  end else begin
                     r_data  <= w_inData;
                     r_keep  <= w_inKeep;
                     r_user  <= core_tuser_i;
                     r_state <= core_tlast_i ? HOLD_LAST : HOLD_WAIT;
                  end
               end
            end
            HOLD_LAST: if (m_axis_tready_i) r_state <= HOLD_EMPTY;
            default:   r_state <= HOLD_EMPTY;
         endcase
      end
   end

`ifdef ASCON_UNPADDER_ERR_EN
   logic       r_err;
   logic       r_midPkt;
   axi_tuser_t r_prevUser;
   logic       w_badKeep;
   logic       w_badUser;

   // A last keep is legal only as a run of ones from bit 0 (x & (x+1) == 0).
   assign w_badKeep = core_tlast_i ? ((core_tkeep_i & (core_tkeep_i + 8'd1)) != 8'd0)
                                   : (core_tkeep_i != 8'hFF);
   assign w_badUser = r_midPkt && (core_tuser_i != r_prevUser);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err      <= 1'b0;
         r_midPkt   <= 1'b0;
         r_prevUser <= TUSER_CT;
      end else if (w_cFire) begin
         r_err      <= r_err | w_badKeep | w_badUser;
         r_midPkt   <= !core_tlast_i;
         r_prevUser <= core_tuser_i;
      end
   end

   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_unpadder.sv
// Randomized self-checking bench for ascon_unpadder against a packet-level reference model.
// Expects err_o activity only when ASCON_UNPADDER_ERR_EN is defined.
module tb_ascon_unpadder;
   import ascon_unpadder_pkg::*;

   logic        clk;
   logic        rst;
   ascon_mode_t mode_i;
   logic [63:0] core_tdata_i;
   logic [7:0]  core_tkeep_i;
   axi_tuser_t  core_tuser_i;
   logic        core_tlast_i;
   logic        core_tvalid_i;
   logic        core_tready_o;
   logic [63:0] m_axis_tdata_o;
   logic [7:0]  m_axis_tkeep_o;
   axi_tuser_t  m_axis_tuser_o;
   logic        m_axis_tlast_o;
   logic        m_axis_tvalid_o;
   logic        m_axis_tready_i;
   logic [31:0] msg_bytes_o;
   logic        err_o;

   int checks   = 0;
   int failures = 0;

   bit [63:0] pktData[$];
   bit [7:0]  pktKeep[$];

   ascon_unpadder dut (
      .clk            (clk),
      .rst            (rst),
      .mode_i         (mode_i),
      .core_tdata_i   (core_tdata_i),
      .core_tkeep_i   (core_tkeep_i),
      .core_tuser_i   (core_tuser_i),
      .core_tlast_i   (core_tlast_i),
      .core_tvalid_i  (core_tvalid_i),
      .core_tready_o  (core_tready_o),
      .m_axis_tdata_o (m_axis_tdata_o),
      .m_axis_tkeep_o (m_axis_tkeep_o),
      .m_axis_tuser_o (m_axis_tuser_o),
      .m_axis_tlast_o (m_axis_tlast_o),
      .m_axis_tvalid_o(m_axis_tvalid_o),
      .m_axis_tready_i(m_axis_tready_i),
      .msg_bytes_o    (msg_bytes_o),
      .err_o          (err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int popc(input bit [7:0] k);
      int c = 0;
      for (int i = 0; i < 8; i++) if (k[i]) c++;
      return c;
   endfunction

   function automatic bit [63:0] maskData(input bit [63:0] d, input bit [7:0] k);
      bit [63:0] r = '0;
      for (int i = 0; i < 8; i++) if (k[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Reference model builds the expected beat list for pktData/pktKeep, then drives and observes.
   task automatic applyStimulus(input ascon_mode_t mode, input axi_tuser_t user, input bit toggleReady);
      bit [63:0] eData[$];
      bit [7:0]  eKeep[$];
      bit        eLast[$];
      int        n, total, wi, bi, cyc;
      bit        dropEn, hold, stall, tog;
      bit [7:0]  k;
      logic [63:0] sData;
      logic [7:0]  sKeep;
      logic        sLast;

      n      = pktData.size();
      total  = 0;
      dropEn = ((mode == MODE_AEAD_ENC) || (mode == MODE_AEAD_DEC)) && (user != TUSER_TAG);
      for (int i = 0; i < n; i++) begin
         k = (user == TUSER_TAG) ? 8'hFF : pktKeep[i];
         if ((i == n - 1) && (n > 1) && (k == 8'h00) && dropEn) begin
            eLast[eLast.size() - 1] = 1'b1;
         end else begin
            eData.push_back(maskData(pktData[i], k));
            eKeep.push_back(k);
            eLast.push_back(i == n - 1);
         end
         total += popc(k);
      end

      mode_i       = mode;
      core_tuser_i = user;
      wi = 0; bi = 0; cyc = 0; hold = 0; stall = 0; tog = 1;
      sData = '0; sKeep = '0; sLast = 0;
      while ((wi < n || bi < eData.size()) && cyc < 400) begin
         @(negedge clk);
         if (!hold) begin
            if (wi < n && $urandom_range(0, 3) != 0) begin
               core_tdata_i  = pktData[wi];
               core_tkeep_i  = pktKeep[wi];
               core_tlast_i  = (wi == n - 1);
               core_tvalid_i = 1'b1;
            end else begin
               core_tvalid_i = 1'b0;
            end
         end
         m_axis_tready_i = toggleReady ? tog : ($urandom_range(0, 2) != 0);
         tog = !tog;
         #1;
         if (stall) begin
            checkOutput("stall_valid", {63'd0, m_axis_tvalid_o}, 64'd1);
            checkOutput("stall_data", m_axis_tdata_o, sData);
            checkOutput("stall_keep", {56'd0, m_axis_tkeep_o}, {56'd0, sKeep});
            checkOutput("stall_last", {63'd0, m_axis_tlast_o}, {63'd0, sLast});
         end
         if (m_axis_tvalid_o && m_axis_tready_i) begin
            if (bi < eData.size()) begin
               checkOutput("beat_data", m_axis_tdata_o, eData[bi]);
               checkOutput("beat_keep", {56'd0, m_axis_tkeep_o}, {56'd0, eKeep[bi]});
               checkOutput("beat_last", {63'd0, m_axis_tlast_o}, {63'd0, eLast[bi]});
               checkOutput("beat_user", {62'd0, m_axis_tuser_o}, {62'd0, user});
               if (eLast[bi]) checkOutput("msg_bytes", {32'd0, msg_bytes_o}, 64'(total));
            end else begin
               checkOutput("extra_beat", 64'(bi), 64'(eData.size()));
            end
            bi++;
         end
         stall = m_axis_tvalid_o && !m_axis_tready_i;
         sData = m_axis_tdata_o;
         sKeep = m_axis_tkeep_o;
         sLast = m_axis_tlast_o;
         if (core_tvalid_i && core_tready_o) begin
            wi++;
            hold = 0;
         end else begin
            hold = core_tvalid_i;
         end
         cyc++;
      end
      checkOutput("pkt_complete", {63'd0, (wi == n) && (bi == eData.size())}, 64'd1);
      @(negedge clk);
      core_tvalid_i   = 1'b0;
      m_axis_tready_i = 1'b0;
      pktData.delete();
      pktKeep.delete();
   endtask

   task automatic addWord(input bit [63:0] d, input bit [7:0] k);
      pktData.push_back(d);
      pktKeep.push_back(k);
   endtask

   function automatic bit [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic bit [7:0] lowKeep(input int nBytes);
      bit [8:0] t;
      t = (9'd1 << nBytes) - 9'd1;
      return t[7:0];
   endfunction

   initial begin
      int  len;
      bit  expErr;
      rst             = 1'b0;
      mode_i          = MODE_AEAD_ENC;
      core_tdata_i    = '0;
      core_tkeep_i    = '0;
      core_tuser_i    = TUSER_CT;
      core_tlast_i    = 1'b0;
      core_tvalid_i   = 1'b0;
      m_axis_tready_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_core_tready", {63'd0, core_tready_o}, 64'd0);
      checkOutput("rst_m_tvalid", {63'd0, m_axis_tvalid_o}, 64'd0);
      checkOutput("rst_m_tdata", m_axis_tdata_o, 64'd0);
      checkOutput("rst_m_tkeep", {56'd0, m_axis_tkeep_o}, 64'd0);
      checkOutput("rst_m_tlast", {63'd0, m_axis_tlast_o}, 64'd0);
      checkOutput("rst_msg_bytes", {32'd0, msg_bytes_o}, 64'd0);
      checkOutput("rst_err", {63'd0, err_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      addWord(rnd64(), 8'hFF); addWord(rnd64(), 8'hFF);
      applyStimulus(MODE_AEAD_ENC, TUSER_CT, 1'b0);
      addWord(rnd64(), 8'h00);
      applyStimulus(MODE_AEAD_DEC, TUSER_PT, 1'b0);
      for (int i = 0; i < 4; i++) addWord(rnd64(), 8'hFF);
      applyStimulus(MODE_HASH, TUSER_MSG, 1'b1);
      addWord(rnd64(), 8'hFF); addWord(rnd64(), 8'h00);
      applyStimulus(MODE_XOF, TUSER_MSG, 1'b0);
      addWord(rnd64(), 8'hFF); addWord(rnd64(), 8'h00);
      applyStimulus(MODE_AEAD_ENC, TUSER_TAG, 1'b0);

      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 5);
         for (int i = 0; i < len - 1; i++) addWord(rnd64(), 8'hFF);
         addWord(rnd64(), ($urandom_range(0, 2) == 0) ? 8'h00 : lowKeep($urandom_range(0, 8)));
         applyStimulus(ascon_mode_t'($urandom_range(0, 3)), axi_tuser_t'($urandom_range(0, 3)),
                       $urandom_range(0, 3) == 0);
      end
      checkOutput("err_clean", {63'd0, err_o}, 64'd0);

`ifdef ASCON_UNPADDER_ERR_EN
      expErr = 1'b1;
`else
      expErr = 1'b0;
`endif
      addWord(rnd64(), 8'h0F); addWord(rnd64(), 8'hFF);
      applyStimulus(MODE_HASH, TUSER_MSG, 1'b0);
      checkOutput("err_bad_keep", {63'd0, err_o}, {63'd0, expErr});
      repeat (3) @(negedge clk);
      #1;
      checkOutput("err_sticky", {63'd0, err_o}, {63'd0, expErr});

      // Reset while a word sits in the hold register.
      @(negedge clk);
      core_tdata_i  = rnd64();
      core_tkeep_i  = 8'hFF;
      core_tlast_i  = 1'b0;
      core_tvalid_i = 1'b1;
      @(negedge clk);
      core_tvalid_i = 1'b0;
      #1;
      checkOutput("mid_no_valid", {63'd0, m_axis_tvalid_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_tdata", m_axis_tdata_o, 64'd0);
      checkOutput("mid_rst_tready", {63'd0, core_tready_o}, 64'd0);
      checkOutput("mid_rst_bytes", {32'd0, msg_bytes_o}, 64'd0);
      checkOutput("mid_rst_err", {63'd0, err_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      addWord(64'h1122334455667788, 8'h07); addWord(rnd64(), 8'h00);
      applyStimulus(MODE_AEAD_ENC, TUSER_CT, 1'b0);
      addWord(rnd64(), 8'hFF); addWord(rnd64(), 8'h03);
      applyStimulus(MODE_AEAD_DEC, TUSER_PT, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
